redstone_cmd_master: RTL and testbench
======================================

Name: redstone_cmd_master

Overview:
- Host-side initiator for the redstone UART command protocol: issues READ_OUTPUTS (0x01), CHANGE_INPUT (0x02) and RESET (0xA5) commands and collects the output-bit response.
- Sits between a local command port and byte-level uart_transmit/uart_receive instances.
- Used for FPGA-to-FPGA links and as the loopback driver for board self-test.

Parameters:
- NUM_OUTPUTS, 16, width of the redstone output vector returned by READ_OUTPUTS.
- NUM_O_BYTES, 2, response byte count; must equal ceil(NUM_OUTPUTS/8).
- NUM_I_BYTES, 2, CHANGE_INPUT argument byte count.
- IDX_W, 8, input index width; IDX_W+8 <= NUM_I_BYTES*8.
- TIMEOUT_CYCLES, 1000000, maximum i_clk cycles to wait for one response byte or for tx_done.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command request; accepted when o_cmd_ready is high on the same edge.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_op  in  2  0 = READ_OUTPUTS, 1 = CHANGE_INPUT, 2 = RESET, 3 = reserved.
- i_input_idx  in  IDX_W  input index for CHANGE_INPUT.
- i_input_val  in  1  new input level for CHANGE_INPUT.
- o_outputs  out  NUM_OUTPUTS  last successfully read output vector.
- o_outputs_valid  out  1  one-cycle pulse when o_outputs is updated.
- o_done  out  1  one-cycle pulse on successful completion of any command.
- o_error  out  1  sticky timeout or reserved-op flag; cleared by acceptance of the next command.
- o_tx_data  out  8  byte to the transmitter.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- i_tx_ready  in  1  transmitter idle.
- i_tx_done  in  1  byte sent; may be a level held several cycles.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  receiver done flag; may be held high for multiple cycles.

Behaviour:
- Reset values:
  - state IDLE; o_cmd_ready 1.
  - o_outputs 0; o_outputs_valid, o_done, o_error, o_tx_start 0; o_tx_data 0x00.
  - All counters 0.
- Acceptance:
  - i_cmd_valid && o_cmd_ready latches op, idx and val, and clears o_error.
  - op 3 → o_error = 1 and return to IDLE next cycle; nothing is transmitted.
- States:
  - IDLE → SEND_OP.
  - SEND_OP: wait for i_tx_ready. Drive the opcode byte on o_tx_data and pulse o_tx_start for 1 cycle → WAIT_TX.
  - WAIT_TX: wait for rising edge of i_tx_done (edge-detected internally, because done may be held).
    - After the opcode: READ → RECV; CHANGE → SEND_ARG with arg count NUM_I_BYTES; RESET → DONE.
    - After an argument byte: decrement arg count; nonzero → SEND_ARG, zero → DONE.
  - SEND_ARG:
    - Argument word W = {zero-pad, idx, 7'b0, val}, NUM_I_BYTES*8 bits.
    - Bytes go MSB first: byte k (k = 0 first) = W[(NUM_I_BYTES-1-k)*8 +: 8].
    - The responder shifts the argument left and uses index = W>>8, value = W&1.
  - RECV:
    - Capture on the rising edge of i_rx_valid only; a held level counts once.
    - Byte k (k = 0 first) fills shift_reg[k*8 +: 8], i.e. LSB byte first.
    - After NUM_O_BYTES bytes: o_outputs ← shift_reg[NUM_OUTPUTS-1:0] and pulse o_outputs_valid → DONE.
  - DONE: pulse o_done for 1 cycle → IDLE.
  - ERR: set o_error, no o_done → IDLE. o_outputs keeps its old value.
- Timeout:
  - A counter resets on entry to WAIT_TX or RECV and on every accepted rx byte.
  - Reaching TIMEOUT_CYCLES-1 → ERR.
- Boundary conditions:
  - Any i_rx_valid edge seen outside RECV is ignored.
  - Response bytes beyond NUM_O_BYTES arriving in IDLE are dropped.
  - A partial response is never published.
  - i_rst mid-command returns to IDLE on the next edge and clears all outputs. A byte already started by the transmitter is not aborted.
  - i_cmd_valid while busy is ignored. No queue; the requester holds i_cmd_valid until it sees ready.
  - Latency: the opcode o_tx_start is asserted 1 cycle after acceptance when i_tx_ready is already high.

Decomposition:
- Shared package/header redstone_proto: opcode constants CMD_SEND_OUTPUTS = 8'h01, CMD_CHANGE_INPUT = 8'h02, CMD_RESET = 8'hA5; the op encoding; state encodings.
- One sub-module: rise_detect (registered edge detector), instantiated twice for i_tx_done and i_rx_valid.

Test Plan:
- READ_OUTPUTS with responder bytes 0x3C then 0xA5 → tx sends 0x01; o_outputs = 16'hA53C; o_outputs_valid and o_done pulse once.
- CHANGE_INPUT, idx = 0x05, val = 1, NUM_I_BYTES = 2 → tx sequence 0x02, 0x05, 0x01; o_done pulses; o_outputs unchanged.
- RESET → single byte 0xA5, o_done pulses, no rx wait.
- READ_OUTPUTS, responder sends only 1 byte, TIMEOUT_CYCLES = 50 → o_error = 1 after 50 idle cycles, no o_outputs_valid, o_outputs keeps its old value.
- i_rx_valid held high for 20 cycles per byte, and i_tx_done held high → each byte counted exactly once; result identical to the first READ_OUTPUTS scenario.
- Assert i_rst during the second argument byte → next cycle IDLE, o_cmd_ready = 1, all outputs 0; a following READ completes normally.

Source files
------------

// File: rtl/redstone_cmd_master_pkg.sv
// Shared protocol constants, command-op encoding and FSM state encoding for the
// redstone UART command master.
package redstone_cmd_master_pkg;

    localparam logic [7:0] CMD_SEND_OUTPUTS = 8'h01;
    localparam logic [7:0] CMD_CHANGE_INPUT = 8'h02;
    localparam logic [7:0] CMD_RESET        = 8'hA5;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_CHANGE = 2'd1,
        OP_RESET  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_OP  = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_SEND_ARG = 3'd3,
        ST_RECV     = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    function automatic logic [7:0] op_byte(input op_e op);
        case (op)
            OP_READ:   op_byte = CMD_SEND_OUTPUTS;
            OP_CHANGE: op_byte = CMD_CHANGE_INPUT;
            OP_RESET:  op_byte = CMD_RESET;
            default:   op_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/redstone_cmd_master_if.sv
// Command port plus byte-level UART transmitter/receiver hookup of the redstone
// command master, bundled as one interface.
interface redstone_cmd_master_if #(
    parameter int NUM_OUTPUTS = 16,
    parameter int IDX_W       = 8
);
    // Command handshake: a command is taken on any clock edge where i_cmd_valid
    // and o_cmd_ready are both high; the requester holds its fields stable until then.
    logic                   i_cmd_valid;
    logic                   o_cmd_ready;
    logic [1:0]             i_cmd_op;
    logic [IDX_W-1:0]       i_input_idx;
    logic                   i_input_val;
    logic [NUM_OUTPUTS-1:0] o_outputs;
    logic                   o_outputs_valid;
    logic                   o_done;
    logic                   o_error;
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_ready;
    logic                   i_tx_done;
    logic [7:0]             i_rx_data;
    logic                   i_rx_valid;

    modport master (
        input  i_cmd_valid, i_cmd_op, i_input_idx, i_input_val,
        input  i_tx_ready, i_tx_done, i_rx_data, i_rx_valid,
        output o_cmd_ready, o_outputs, o_outputs_valid, o_done, o_error,
        output o_tx_data, o_tx_start
    );

    modport slave (
        output i_cmd_valid, i_cmd_op, i_input_idx, i_input_val,
        output i_tx_ready, i_tx_done, i_rx_data, i_rx_valid,
        input  o_cmd_ready, o_outputs, o_outputs_valid, o_done, o_error,
        input  o_tx_data, o_tx_start
    );

endinterface

// File: rtl/redstone_cmd_master_rise_detect.sv
// Registered rising-edge detector: a level held high for many cycles yields a
// single one-cycle pulse, one clock after the rise.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_q <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            level_q <= i_level;
            o_rise  <= i_level & ~level_q;
        end
    end

endmodule

// File: rtl/redstone_cmd_master.sv
// Host-side initiator for the redstone UART command protocol: sends an opcode
// (plus CHANGE_INPUT arguments) and collects the READ_OUTPUTS response bytes.
module redstone_cmd_master
    import redstone_cmd_master_pkg::*;
#(
    parameter int NUM_OUTPUTS    = 16,
    parameter int NUM_O_BYTES    = 2,
    parameter int NUM_I_BYTES    = 2,
    parameter int IDX_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    redstone_cmd_master_if.master bus,
    output state_e               dbg_state
);

    localparam int ARG_W  = NUM_I_BYTES * 8;
    localparam int SH_W   = NUM_O_BYTES * 8;
    localparam int ARGC_W = $clog2(NUM_I_BYTES + 1);
    localparam int RXC_W  = $clog2(NUM_O_BYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state;
    op_e               op_q;
    logic [ARG_W-1:0]  arg_word;
    logic [ARGC_W-1:0] arg_cnt;
    logic              arg_phase;
    logic [RXC_W-1:0]  rx_cnt;
    logic [SH_W-1:0]   shift_reg;
    logic [SH_W-1:0]   shift_next;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        rx_q;
    logic              tx_rise;
    logic              rx_rise;

    // The edge pulses arrive one clock late, so rx_q delays the data to match.
    rise_detect u_tx_done_rise (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_level(bus.i_tx_done),
        .o_rise (tx_rise)
    );

    rise_detect u_rx_valid_rise (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_level(bus.i_rx_valid),
        .o_rise (rx_rise)
    );

    // Response bytes enter at the top, so the first byte ends up in bits [7:0].
    assign shift_next      = (shift_reg >> 8) | (SH_W'(rx_q) << (SH_W - 8));
    assign bus.o_cmd_ready = (state == ST_IDLE);
    assign dbg_state       = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= ST_IDLE;
            op_q                <= OP_READ;
            arg_word            <= '0;
            arg_cnt             <= '0;
            arg_phase           <= 1'b0;
            rx_cnt              <= '0;
            shift_reg           <= '0;
            to_cnt              <= '0;
            rx_q                <= 8'h00;
            bus.o_outputs       <= '0;
            bus.o_outputs_valid <= 1'b0;
            bus.o_done          <= 1'b0;
            bus.o_error         <= 1'b0;
            bus.o_tx_start      <= 1'b0;
            bus.o_tx_data       <= 8'h00;
        end else begin
            rx_q                <= bus.i_rx_data;
            bus.o_tx_start      <= 1'b0;
            bus.o_done          <= 1'b0;
            bus.o_outputs_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        op_q     <= op_e'(bus.i_cmd_op);
                        arg_word <= ARG_W'({bus.i_input_idx, 7'b0, bus.i_input_val});
                        if (op_e'(bus.i_cmd_op) == OP_RSVD) begin
                            bus.o_error <= 1'b1;
                        end else begin
                            bus.o_error <= 1'b0;
                            state       <= ST_SEND_OP;
                        end
                    end
                end
                ST_SEND_OP: begin
                    if (bus.i_tx_ready) begin
                        bus.o_tx_data  <= op_byte(op_q);
                        bus.o_tx_start <= 1'b1;
                        arg_phase      <= 1'b0;
                        to_cnt         <= '0;
                        state          <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (tx_rise) begin
                        if (!arg_phase) begin
                            case (op_q)
                                OP_READ: begin
                                    rx_cnt <= '0;
                                    to_cnt <= '0;
                                    state  <= ST_RECV;
                                end
                                OP_CHANGE: begin
                                    arg_cnt <= ARGC_W'(NUM_I_BYTES);
                                    state   <= ST_SEND_ARG;
                                end
                                default: state <= ST_DONE;
                            endcase
                        end else begin
                            arg_cnt <= arg_cnt - ARGC_W'(1);
                            state   <= (arg_cnt == ARGC_W'(1)) ? ST_DONE : ST_SEND_ARG;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_SEND_ARG: begin
                    if (bus.i_tx_ready) begin
                        bus.o_tx_data  <= arg_word[ARG_W-1 -: 8];
                        arg_word       <= arg_word << 8;
                        bus.o_tx_start <= 1'b1;
                        arg_phase      <= 1'b1;
                        to_cnt         <= '0;
                        state          <= ST_WAIT_TX;
                    end
                end
                ST_RECV: begin
                    if (rx_rise) begin
                        shift_reg <= shift_next;
                        to_cnt    <= '0;
                        rx_cnt    <= rx_cnt + RXC_W'(1);
                        if (rx_cnt == RXC_W'(NUM_O_BYTES - 1)) begin
                            bus.o_outputs       <= shift_next[NUM_OUTPUTS-1:0];
                            bus.o_outputs_valid <= 1'b1;
                            state               <= ST_DONE;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.o_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_ERR: begin
                    bus.o_error <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redstone_cmd_master.sv
// Directed bench for redstone_cmd_master with a behavioural UART transmitter,
// a task-driven responder and an expected-byte queue for transmitted bytes.
module tb_redstone_cmd_master;
    import redstone_cmd_master_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;

    redstone_cmd_master_if #(.NUM_OUTPUTS(16), .IDX_W(8)) bus ();

    redstone_cmd_master #(
        .NUM_OUTPUTS(16), .NUM_O_BYTES(2), .NUM_I_BYTES(2), .IDX_W(8), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         ov_cnt = 0;
    int         start_cnt = 0;
    int         recv_cnt = 0;
    int         tx_hold = 1;

    // Clock and reset
    always #5 clk = ~clk;

    // Pulse counters sample the value held during the cycle that just ended.
    always @(posedge clk) begin
        if (bus.o_done === 1'b1) done_cnt++;
        if (bus.o_outputs_valid === 1'b1) ov_cnt++;
        if (bus.o_tx_start === 1'b1) start_cnt++;
        if (dbg_state === ST_RECV) recv_cnt++;
    end

    // Transmitter model and scoreboard of transmitted bytes
    initial begin
        logic [7:0] exp_b;
        bus.i_tx_ready = 1'b1;
        bus.i_tx_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %02h, no byte expected", bus.o_tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.o_tx_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %02h want %02h", bus.o_tx_data, exp_b);
                    end
                end
                bus.i_tx_ready = 1'b0;
                repeat (6) @(negedge clk);
                bus.i_tx_done = 1'b1;
                repeat (tx_hold) @(negedge clk);
                bus.i_tx_done  = 1'b0;
                bus.i_tx_ready = 1'b1;
            end
        end
    end

    // Driver tasks
    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] idx, input logic val,
                             output bit ok);
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = op;
        bus.i_input_idx = idx;
        bus.i_input_val = val;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.o_cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input int hold);
        @(negedge clk);
        bus.i_rx_data  = d;
        bus.i_rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input state_e s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dbg_state === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_finish(input int d0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || bus.o_error === 1'b1) break;
        end
        repeat (2) @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        bus.i_cmd_valid = 1'b0; bus.i_cmd_op = 2'd0; bus.i_input_idx = 8'h00; bus.i_input_val = 1'b0;
        bus.i_rx_data = 8'h00; bus.i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (bus.o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.o_cmd_ready); end
        n_checks++; if (bus.o_outputs !== 16'h0000) begin n_fail++; $display("FAIL rst_outputs: got %04h want 0000", bus.o_outputs); end
        n_checks++; if (bus.o_outputs_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b want 0", bus.o_outputs_valid); end
        n_checks++; if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
        n_checks++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", bus.o_error); end
        n_checks++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", bus.o_tx_start); end
        n_checks++; if (bus.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %02h want 00", bus.o_tx_data); end
    endtask

    task automatic test_read();
        bit ok;
        int d0 = done_cnt, v0 = ov_cnt;
        exp_q.push_back(8'h01);
        issue_cmd(2'd0, 8'h00, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_accept: got no ready want ready"); end
        n_checks++; if (dbg_state !== ST_SEND_OP) begin n_fail++; $display("FAIL read_send_op: got %0d want %0d", dbg_state, ST_SEND_OP); end
        @(negedge clk);
        n_checks++; if (bus.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL read_start_latency: got %b want 1", bus.o_tx_start); end
        wait_state(ST_RECV, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_recv: got no RECV want RECV"); end
        send_rx(8'h3C, 1);
        send_rx(8'hA5, 1);
        wait_finish(d0);
        n_checks++; if (bus.o_outputs !== 16'hA53C) begin n_fail++; $display("FAIL read_outputs: got %04h want a53c", bus.o_outputs); end
        n_checks++; if (ov_cnt - v0 != 1) begin n_fail++; $display("FAIL read_ov_pulses: got %0d want 1", ov_cnt - v0); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL read_done_pulses: got %0d want 1", done_cnt - d0); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL read_tx_count: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_change();
        bit ok;
        int d0 = done_cnt, v0 = ov_cnt;
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h01);
        issue_cmd(2'd1, 8'h05, 1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL change_accept: got no ready want ready"); end
        wait_finish(d0);
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL change_done: got %0d want 1", done_cnt - d0); end
        n_checks++; if (ov_cnt != v0) begin n_fail++; $display("FAIL change_ov: got %0d want 0", ov_cnt - v0); end
        n_checks++; if (bus.o_outputs !== 16'hA53C) begin n_fail++; $display("FAIL change_outputs: got %04h want a53c", bus.o_outputs); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_tx_count: got %0d left want 0", exp_q.size()); end
        n_checks++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL change_error: got %b want 0", bus.o_error); end
    endtask

    task automatic test_reset_cmd();
        bit ok;
        int d0 = done_cnt, r0 = recv_cnt;
        exp_q.push_back(8'hA5);
        issue_cmd(2'd2, 8'h00, 1'b0, ok);
        wait_finish(d0);
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL resetcmd_done: got %0d want 1", done_cnt - d0); end
        n_checks++; if (recv_cnt != r0) begin n_fail++; $display("FAIL resetcmd_no_recv: got %0d want 0", recv_cnt - r0); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL resetcmd_tx_count: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reserved();
        bit ok;
        int d0 = done_cnt, s0 = start_cnt;
        issue_cmd(2'd3, 8'h00, 1'b0, ok);
        n_checks++; if (bus.o_error !== 1'b1) begin n_fail++; $display("FAIL rsvd_error: got %b want 1", bus.o_error); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rsvd_state: got %0d want %0d", dbg_state, ST_IDLE); end
        repeat (20) @(negedge clk);
        n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL rsvd_no_tx: got %0d starts want 0", start_cnt - s0); end
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL rsvd_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0 = done_cnt, v0 = ov_cnt, cyc = 0;
        exp_q.push_back(8'h01);
        issue_cmd(2'd0, 8'h00, 1'b0, ok);
        n_checks++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL to_error_clear: got %b want 0", bus.o_error); end
        wait_state(ST_RECV, ok);
        send_rx(8'h11, 1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.o_error === 1'b1) break;
        end
        n_checks++; if (bus.o_error !== 1'b1) begin n_fail++; $display("FAIL to_error: got %b want 1", bus.o_error); end
        n_checks++; if (cyc < 35 || cyc > 60) begin n_fail++; $display("FAIL to_latency: got %0d cycles want 35..60", cyc); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL to_state: got %0d want %0d", dbg_state, ST_IDLE); end
        send_rx(8'h77, 1);
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_outputs !== 16'hA53C) begin n_fail++; $display("FAIL to_outputs_kept: got %04h want a53c", bus.o_outputs); end
        n_checks++; if (ov_cnt != v0) begin n_fail++; $display("FAIL to_no_ov: got %0d want 0", ov_cnt - v0); end
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL to_no_done: got %0d want 0", done_cnt - d0); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL to_idle_rx_drop: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int seen = 0, d0, v0;
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h01);
        issue_cmd(2'd1, 8'h05, 1'b1, ok);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) seen++;
            if (seen == 3) break;
        end
        n_checks++; if (seen != 3) begin n_fail++; $display("FAIL mid_second_arg: got %0d starts want 3", seen); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (bus.o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", bus.o_cmd_ready); end
        n_checks++; if (bus.o_outputs !== 16'h0000) begin n_fail++; $display("FAIL mid_outputs: got %04h want 0000", bus.o_outputs); end
        n_checks++; if (bus.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %02h want 00", bus.o_tx_data); end
        n_checks++; if ({bus.o_tx_start, bus.o_done, bus.o_error, bus.o_outputs_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_flags: got %b want 0000", {bus.o_tx_start, bus.o_done, bus.o_error, bus.o_outputs_valid});
        end
        d0 = done_cnt; v0 = ov_cnt;
        exp_q.push_back(8'h01);
        issue_cmd(2'd0, 8'h00, 1'b0, ok);
        wait_state(ST_RECV, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_read_recv: got no RECV want RECV"); end
        send_rx(8'h34, 1);
        send_rx(8'h12, 1);
        wait_finish(d0);
        n_checks++; if (bus.o_outputs !== 16'h1234) begin n_fail++; $display("FAIL mid_read_outputs: got %04h want 1234", bus.o_outputs); end
        n_checks++; if (ov_cnt - v0 != 1 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL mid_read_pulses: got ov %0d done %0d want 1 1", ov_cnt - v0, done_cnt - d0);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_tx_count: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_held_levels();
        bit ok;
        int d0 = done_cnt, v0 = ov_cnt;
        tx_hold = 5;
        exp_q.push_back(8'h01);
        issue_cmd(2'd0, 8'h00, 1'b0, ok);
        wait_state(ST_RECV, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL held_recv: got no RECV want RECV"); end
        send_rx(8'h3C, 20);
        send_rx(8'hA5, 20);
        wait_finish(d0);
        repeat (6) @(negedge clk);
        n_checks++; if (bus.o_outputs !== 16'hA53C) begin n_fail++; $display("FAIL held_outputs: got %04h want a53c", bus.o_outputs); end
        n_checks++; if (ov_cnt - v0 != 1) begin n_fail++; $display("FAIL held_ov_pulses: got %0d want 1", ov_cnt - v0); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL held_done_pulses: got %0d want 1", done_cnt - d0); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL held_tx_count: got %0d left want 0", exp_q.size()); end
        tx_hold = 1;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_read();
        test_change();
        test_reset_cmd();
        test_reserved();
        test_timeout();
        test_mid_reset();
        test_held_levels();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
